// File: rtl/redmule_pkg.sv
// Shared RedMulE definitions: job register map, peripheral offsets, and the
// types used by the configuration master.
package redmule_pkg;

    localparam int X_ADDR       = 0;
    localparam int OP_SELECTION = 18;
    localparam int REDMULE_REGS = OP_SELECTION - X_ADDR + 1;

    localparam logic [31:0] TRIGGER_OFFS = 32'h0000_0000;
    localparam logic [31:0] ACQUIRE_OFFS = 32'h0000_0004;
    localparam logic [31:0] JOB_OFFS     = 32'h0000_0040;

    localparam int PERIPH_AW = 32;

    typedef enum logic [2:0] {
        CFG_IDLE     = 3'd0,
        CFG_ACQ      = 3'd1,
        CFG_ACQ_RSP  = 3'd2,
        CFG_BACKOFF  = 3'd3,
        CFG_WR       = 3'd4,
        CFG_TRIG     = 3'd5,
        CFG_WAIT_EVT = 3'd6,
        CFG_DONE     = 3'd7
    } cfg_master_state_e;

    typedef struct packed {
        logic                 req;
        logic [PERIPH_AW-1:0] add;
        logic                 wen;
        logic [3:0]           be;
        logic [31:0]          data;
    } periph_req_t;

endpackage

// File: rtl/redmule_cfg_backoff_cnt.sv
// Loadable down-counter that saturates at zero; used for the acquire back-off
// wait and reusable as a watchdog.
module redmule_cfg_backoff_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (load_i) begin
            cnt_reg <= load_val_i;
        end else if (dec_i && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero_o = (cnt_reg == '0);

endmodule

// File: rtl/redmule_cfg_master.sv
// Peripheral-bus initiator that acquires RedMulE, writes one job descriptor,
// triggers it and reports completion with the acquired job id.
module redmule_cfg_master #(
    parameter int                REGS        = redmule_pkg::REDMULE_REGS,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] JOB_OFFS    = ADDR_W'(redmule_pkg::JOB_OFFS),
    parameter int                MAX_RETRY   = 16,
    parameter int                BACKOFF_CYC = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [REGS*32-1:0]   job_regs_i,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [ADDR_W-1:0]    add_o,
    output logic                 wen_o,
    output logic [3:0]           be_o,
    output logic [31:0]          data_o,
    input  logic                 r_valid_i,
    input  logic [31:0]          r_data_i,
    input  logic                 evt_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [7:0]           done_id_o,
    output logic                 err_o,
    output logic                 busy_o
);

    import redmule_pkg::*;

    localparam int IDX_W = (REGS > 1) ? $clog2(REGS) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int BO_W  = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(REGS - 1);
    localparam logic [RTY_W-1:0]  LAST_RTY  = RTY_W'(MAX_RETRY - 1);
    localparam logic [BO_W-1:0]   BO_LOAD   = BO_W'((BACKOFF_CYC > 0) ? BACKOFF_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] TRIG_ADDR = BASE_ADDR + ADDR_W'(TRIGGER_OFFS);
    localparam logic [ADDR_W-1:0] ACQ_ADDR  = BASE_ADDR + ADDR_W'(ACQUIRE_OFFS);

    cfg_master_state_e state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [RTY_W-1:0]  retry_reg, retry_next;
    logic [7:0]        done_id_reg, done_id_next;
    logic              err_reg, err_next;
    logic [31:0]       job_regs_mem [REGS];
    logic              job_accept;
    logic              bo_load, bo_dec, bo_zero;
    logic [ADDR_W-1:0] job_addr;
    periph_req_t       preq;
    logic              unused_rdata;

    assign unused_rdata = ^r_data_i[30:8];
    assign job_addr     = BASE_ADDR + JOB_OFFS + ADDR_W'({idx_reg, 2'b00});

    redmule_cfg_backoff_cnt #(
        .W (BO_W)
    ) u_backoff_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (bo_load),
        .load_val_i (BO_LOAD),
        .dec_i      (bo_dec),
        .zero_o     (bo_zero)
    );

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        retry_next   = retry_reg;
        done_id_next = done_id_reg;
        err_next     = err_reg;
        job_accept   = 1'b0;
        bo_load      = 1'b0;
        bo_dec       = 1'b0;
        preq.req     = 1'b0;
        preq.add     = '0;
        preq.wen     = 1'b1;
        preq.be      = 4'hF;
        preq.data    = '0;
        case (state_reg)
            CFG_IDLE: begin
                if (job_valid_i) begin
                    job_accept = 1'b1;
                    err_next   = 1'b0;
                    retry_next = '0;
                    state_next = CFG_ACQ;
                end
            end
            CFG_ACQ: begin
                preq.req = 1'b1;
                preq.add = PERIPH_AW'(ACQ_ADDR);
                if (gnt_i) state_next = CFG_ACQ_RSP;
            end
            CFG_ACQ_RSP: begin
                if (r_valid_i) begin
                    // Bit 31 set means another master owns the accelerator.
                    if (r_data_i[31]) begin
                        retry_next = retry_reg + 1'b1;
                        if (retry_reg == LAST_RTY) begin
                            err_next   = 1'b1;
                            state_next = CFG_IDLE;
                        end else begin
                            bo_load    = 1'b1;
                            state_next = CFG_BACKOFF;
                        end
                    end else begin
                        done_id_next = r_data_i[7:0];
                        idx_next     = '0;
                        state_next   = CFG_WR;
                    end
                end
            end
            CFG_BACKOFF: begin
                if (bo_zero) state_next = CFG_ACQ;
                else         bo_dec     = 1'b1;
            end
            CFG_WR: begin
                preq.req  = 1'b1;
                preq.wen  = 1'b0;
                preq.add  = PERIPH_AW'(job_addr);
                preq.data = job_regs_mem[idx_reg];
                if (gnt_i) begin
                    if (idx_reg == LAST_IDX) state_next = CFG_TRIG;
                    else                     idx_next   = idx_reg + 1'b1;
                end
            end
            CFG_TRIG: begin
                preq.req = 1'b1;
                preq.wen = 1'b0;
                preq.add = PERIPH_AW'(TRIG_ADDR);
                if (gnt_i) state_next = CFG_WAIT_EVT;
            end
            CFG_WAIT_EVT: begin
                if (evt_i) state_next = CFG_DONE;
            end
            CFG_DONE: begin
                if (done_ready_i) state_next = CFG_IDLE;
            end
            default: state_next = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= CFG_IDLE;
            idx_reg     <= '0;
            retry_reg   <= '0;
            done_id_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            retry_reg   <= retry_next;
            done_id_reg <= done_id_next;
            err_reg     <= err_next;
        end
    end

    // Descriptor storage is plain data, captured only on accept.
    always_ff @(posedge clk_i) begin
        if (job_accept) begin
            for (int i = 0; i < REGS; i++) begin
                job_regs_mem[i] <= job_regs_i[32*i +: 32];
            end
        end
    end

    assign req_o        = preq.req;
    assign add_o        = ADDR_W'(preq.add);
    assign wen_o        = preq.wen;
    assign be_o         = preq.be;
    assign data_o       = preq.data;
    assign job_ready_o  = (state_reg == CFG_IDLE) && !rst_i;
    assign done_valid_o = (state_reg == CFG_DONE);
    assign done_id_o    = done_id_reg;
    assign err_o        = err_reg;
    assign busy_o       = (state_reg != CFG_IDLE);

endmodule

// File: tb/tb_redmule_cfg_master.sv
// Self-checking bench for redmule_cfg_master: a randomized slave model logs
// every granted transfer and each scenario checks the log against the job rules.
module tb_redmule_cfg_master;

    localparam int REGS        = 19;
    localparam int MAX_RETRY   = 16;
    localparam int BACKOFF_CYC = 8;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                job_valid_i = 1'b0;
    logic                job_ready_o;
    logic [REGS*32-1:0]  job_regs_i = '0;
    logic                req_o;
    logic                gnt_i = 1'b0;
    logic [31:0]         add_o;
    logic                wen_o;
    logic [3:0]          be_o;
    logic [31:0]         data_o;
    logic                r_valid_i = 1'b0;
    logic [31:0]         r_data_i = '0;
    logic                evt_i = 1'b0;
    logic                done_valid_o;
    logic                done_ready_i = 1'b0;
    logic [7:0]          done_id_o;
    logic                err_o;
    logic                busy_o;

    int checks = 0;
    int errors = 0;

    // slave model state
    int          gnt_prob = 100;
    logic [31:0] resp_tab [32];
    int          resp_start = 0;
    int          rd_count = 0;
    int          cyc = 0;
    bit          rd_pend = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_add, prev_data;
    logic        prev_wen;
    int          stall_viol = 0;
    logic [31:0] tr_add [$];
    logic [31:0] tr_data [$];
    logic        tr_wen [$];
    int          tr_cyc [$];

    logic [31:0] desc [REGS];

    always #5 clk = ~clk;

    redmule_cfg_master dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .job_valid_i  (job_valid_i),
        .job_ready_o  (job_ready_o),
        .job_regs_i   (job_regs_i),
        .req_o        (req_o),
        .gnt_i        (gnt_i),
        .add_o        (add_o),
        .wen_o        (wen_o),
        .be_o         (be_o),
        .data_o       (data_o),
        .r_valid_i    (r_valid_i),
        .r_data_i     (r_data_i),
        .evt_i        (evt_i),
        .done_valid_o (done_valid_o),
        .done_ready_i (done_ready_i),
        .done_id_o    (done_id_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    // Slave: decides grant on the falling edge, answers reads one cycle later.
    always @(negedge clk) begin
        int ri;
        cyc++;
        if (rd_pend && !rst_i) begin
            ri = rd_count - resp_start;
            r_data_i = (ri >= 0 && ri < 32) ? resp_tab[ri] : 32'hFFFF_FFFF;
            r_valid_i = 1'b1;
            rd_count++;
        end else begin
            r_valid_i = 1'b0;
            r_data_i = $urandom;
        end
        rd_pend = 0;
        if (prev_stall && !rst_i &&
            (req_o !== 1'b1 || add_o !== prev_add || wen_o !== prev_wen || data_o !== prev_data))
            stall_viol++;
        if (req_o === 1'b1 && !rst_i) begin
            gnt_i = ($urandom_range(99) < gnt_prob);
            if (gnt_i) begin
                tr_add.push_back(add_o);
                tr_data.push_back(data_o);
                tr_wen.push_back(wen_o);
                tr_cyc.push_back(cyc);
                if (wen_o) rd_pend = 1;
            end
        end else begin
            gnt_i = 1'b0;
        end
        prev_stall = (req_o === 1'b1) && !gnt_i && !rst_i;
        prev_add   = add_o;
        prev_data  = data_o;
        prev_wen   = wen_o;
    end

    task automatic submit_job();
        int t = 0;
        while (job_ready_o !== 1'b1 && t < 100) begin
            @(posedge clk); #2; t++;
        end
        checks++;
        if (job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_wait: got %b expected 1", job_ready_o);
        end
        for (int i = 0; i < REGS; i++) begin
            desc[i] = $urandom;
            job_regs_i[32*i +: 32] = desc[i];
        end
        job_valid_i = 1'b1;
        @(posedge clk); #1;
        job_valid_i = 1'b0;
        for (int i = 0; i < REGS; i++) job_regs_i[32*i +: 32] = $urandom;
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL accept: got busy=%b err=%b expected busy=1 err=0", busy_o, err_o);
        end
    endtask

    task automatic do_job(input string name, input int n_busy, input bit always_busy,
                          input logic [31:0] ok_resp, input int gprob,
                          input bit early_evt, input int ready_delay);
        int base, n_reads, exp_n, t, gap;
        bit evt_sent;
        logic [31:0] exp_add, exp_data;
        logic exp_wen;
        gnt_prob = gprob;
        for (int i = 0; i < 32; i++)
            resp_tab[i] = (always_busy || i < n_busy) ? 32'hFFFF_FFFF : ok_resp;
        resp_start = rd_count;
        base = tr_add.size();
        submit_job();
        n_reads = always_busy ? MAX_RETRY : n_busy + 1;
        exp_n = always_busy ? n_reads : n_reads + REGS + 1;
        t = 0;
        evt_sent = 0;
        while (tr_add.size() - base < exp_n && t < 5000) begin
            @(posedge clk); #2; t++;
            if (early_evt && !evt_sent && tr_add.size() - base > n_reads) begin
                evt_i = 1'b1;
                @(posedge clk); #1;
                evt_i = 1'b0;
                evt_sent = 1;
            end
        end
        checks++;
        if (tr_add.size() - base != exp_n) begin
            errors++;
            $display("FAIL %s_xfer_count: got %0d expected %0d", name, tr_add.size() - base, exp_n);
        end
        if (always_busy) begin
            t = 0;
            while (busy_o !== 1'b0 && t < 50) begin
                @(posedge clk); #2; t++;
            end
            repeat (30) @(posedge clk);
            #2;
            checks++;
            if (tr_add.size() - base != exp_n) begin
                errors++;
                $display("FAIL %s_no_extra_xfer: got %0d expected %0d", name, tr_add.size() - base, exp_n);
            end
            checks++;
            if (err_o !== 1'b1 || busy_o !== 1'b0 || job_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_err_idle: got err=%b busy=%b ready=%b expected err=1 busy=0 ready=1",
                         name, err_o, busy_o, job_ready_o);
            end
        end
        for (int k = 0; k < exp_n && k < tr_add.size() - base; k++) begin
            if (k < n_reads) begin
                exp_add = 32'h4; exp_wen = 1'b1; exp_data = '0;
            end else if (k < n_reads + REGS) begin
                exp_add = 32'h40 + 32'(4 * (k - n_reads)); exp_wen = 1'b0; exp_data = desc[k - n_reads];
            end else begin
                exp_add = 32'h0; exp_wen = 1'b0; exp_data = '0;
            end
            checks++;
            if (tr_add[base+k] !== exp_add || tr_wen[base+k] !== exp_wen ||
                (!exp_wen && tr_data[base+k] !== exp_data)) begin
                errors++;
                $display("FAIL %s_xfer%0d: got add=%h wen=%b data=%h expected add=%h wen=%b data=%h",
                         name, k, tr_add[base+k], tr_wen[base+k], tr_data[base+k], exp_add, exp_wen, exp_data);
            end
        end
        if (gprob == 100) begin
            for (int k = 1; k < n_reads && k < tr_add.size() - base; k++) begin
                gap = tr_cyc[base+k] - tr_cyc[base+k-1] - 1;
                checks++;
                if (gap < BACKOFF_CYC) begin
                    errors++;
                    $display("FAIL %s_backoff%0d: got %0d idle cycles expected >= %0d", name, k, gap, BACKOFF_CYC);
                end
            end
        end
        if (!always_busy) begin
            repeat (3) @(posedge clk);
            #2;
            checks++;
            if (done_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_wait_evt: got done_valid=%b busy=%b expected 0 1", name, done_valid_o, busy_o);
            end
            evt_i = 1'b1;
            @(posedge clk); #1;
            evt_i = 1'b0;
            t = 0;
            while (done_valid_o !== 1'b1 && t < 10) begin
                @(posedge clk); #2; t++;
            end
            checks++;
            if (done_valid_o !== 1'b1 || done_id_o !== ok_resp[7:0] || job_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_done: got valid=%b id=%h ready=%b expected 1 %h 0",
                         name, done_valid_o, done_id_o, job_ready_o, ok_resp[7:0]);
            end
            for (int d = 0; d < ready_delay; d++) begin
                @(posedge clk); #2;
                checks++;
                if (done_valid_o !== 1'b1 || done_id_o !== ok_resp[7:0] || job_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_done_hold%0d: got valid=%b id=%h ready=%b expected 1 %h 0",
                             name, d, done_valid_o, done_id_o, job_ready_o, ok_resp[7:0]);
                end
            end
            done_ready_i = 1'b1;
            @(posedge clk); #1;
            done_ready_i = 1'b0;
            checks++;
            if (done_valid_o !== 1'b0 || busy_o !== 1'b0 || job_ready_o !== 1'b1 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_release: got valid=%b busy=%b ready=%b err=%b expected 0 0 1 0",
                         name, done_valid_o, busy_o, job_ready_o, err_o);
            end
        end
        $display("job %s: transfers=%0d reads=%0d id=%h err=%b", name, tr_add.size() - base,
                 n_reads, done_id_o, err_o);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_o !== 1'b0 || add_o !== 32'h0 || wen_o !== 1'b1 || be_o !== 4'hF || data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b add=%h wen=%b be=%h data=%h expected 0 0 1 f 0",
                     req_o, add_o, wen_o, be_o, data_o);
        end
        checks++;
        if (job_ready_o !== 1'b0 || done_valid_o !== 1'b0 || done_id_o !== 8'h0 ||
            err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got ready=%b dv=%b id=%h err=%b busy=%b expected all 0",
                     job_ready_o, done_valid_o, done_id_o, err_o, busy_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", job_ready_o);
        end
    endtask

    task automatic test_reset_mid_write();
        int base, t;
        gnt_prob = 100;
        for (int i = 0; i < 32; i++) resp_tab[i] = 32'h0000_0007;
        resp_start = rd_count;
        base = tr_add.size();
        submit_job();
        t = 0;
        while (tr_add.size() - base < 7 && t < 200) begin
            @(posedge clk); #2; t++;
        end
        checks++;
        if (tr_add.size() - base != 7 || req_o !== 1'b1 || wen_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pos: got xfers=%0d req=%b wen=%b expected 7 1 0",
                     tr_add.size() - base, req_o, wen_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0 || done_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got req=%b busy=%b dv=%b expected 0 0 0", req_o, busy_o, done_valid_o);
        end
        @(posedge clk); #2;
        rst_i = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0 || job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle: got req=%b busy=%b ready=%b expected 0 0 1", req_o, busy_o, job_ready_o);
        end
        do_job("after_reset", 0, 0, 32'h0000_0009, 100, 0, 0);
    endtask

    task automatic test_random_stalls();
        for (int it = 0; it < 3; it++) begin
            do_job($sformatf("stall%0d", it), int'($urandom_range(2)), 0,
                   $urandom & 32'h7FFF_FFFF, 50, 0, int'($urandom_range(3)));
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_stability: got %0d violations expected 0", stall_viol);
        end
    endtask

    initial begin
        test_reset();
        do_job("free_slave", 0, 0, 32'h0000_0003, 100, 0, 0);
        do_job("busy_slave", 2, 0, 32'h0000_0005, 100, 0, 2);
        do_job("always_busy", 0, 1, 32'h0, 100, 0, 0);
        test_random_stalls();
        test_reset_mid_write();
        do_job("early_evt", 0, 0, 32'h0000_00A5, 70, 1, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
